// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the vertical region encoding.
// Imported by the vertical counter and any downstream pixel logic.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        V_ACT  = 2'd0,
        V_FP   = 2'd1,
        V_SYNC = 2'd2,
        V_BP   = 2'd3
    } v_state_e;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = 800;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = 525;

endpackage

// File: rtl/vga_vcounter.sv
// Vertical line counter and region FSM for the VGA driver. All outputs are
// registered from the next line value so they switch on the same edge as count.
module vga_vcounter
    import vga_timing_pkg::*;
#(
    parameter int   N        = 9,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0,
    parameter int   FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Venable,
    output logic [N:0]         count,
    output logic               vsync,
    output logic               vde,
    output logic [1:0]         state,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [N:0] C_FP_START   = (N+1)'(V_ACTIVE);
    localparam logic [N:0] C_SYNC_START = (N+1)'(V_ACTIVE + V_FP);
    localparam logic [N:0] C_BP_START   = (N+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [N:0] C_LAST       = (N+1)'(V_TOTAL - 1);
    localparam logic [N:0] C_ONE        = {{N{1'b0}}, 1'b1};
    localparam logic [FRAME_W-1:0] C_FRAME_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};

    if ((V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1)) begin : g_bad_region
        $error("vga_vcounter: every vertical region needs at least one line");
    end
    if (V_TOTAL > (1 << (N + 1))) begin : g_bad_width
        $error("vga_vcounter: V_TOTAL-1 does not fit in count[N:0]");
    end

    logic [N:0]         r_count;
    v_state_e           r_state;
    logic               r_vsync;
    logic               r_vde;
    logic               r_frame_start;
    logic [FRAME_W-1:0] r_frame_cnt;

    logic               w_last;
    logic               w_out_of_range;
    logic [N:0]         w_next_count;
    v_state_e           w_next_state;

    // Next line value and region, evaluated as if Venable were high this cycle
    always_comb begin
        w_last         = (r_count == C_LAST);
        w_out_of_range = (r_count > C_LAST);
        w_next_count   = r_count + C_ONE;
        w_next_state   = r_state;

        if (w_last || w_out_of_range) begin
            w_next_count = '0;
        end else begin
            w_next_count = r_count + C_ONE;
        end

        case (r_state)
            vga_timing_pkg::V_ACT: begin
                if (w_next_count == C_FP_START) w_next_state = vga_timing_pkg::V_FP;
                else                            w_next_state = vga_timing_pkg::V_ACT;
            end
            vga_timing_pkg::V_FP: begin
                if (w_next_count == C_SYNC_START) w_next_state = vga_timing_pkg::V_SYNC;
                else                              w_next_state = vga_timing_pkg::V_FP;
            end
            vga_timing_pkg::V_SYNC: begin
                if (w_next_count == C_BP_START) w_next_state = vga_timing_pkg::V_BP;
                else                            w_next_state = vga_timing_pkg::V_SYNC;
            end
            vga_timing_pkg::V_BP: begin
                if (w_next_count == '0) w_next_state = vga_timing_pkg::V_ACT;
                else                    w_next_state = vga_timing_pkg::V_BP;
            end
            default: w_next_state = vga_timing_pkg::V_ACT;
        endcase

        // A corrupted count restarts the frame cleanly
        if (w_out_of_range) begin
            w_next_state = vga_timing_pkg::V_ACT;
        end else begin
            w_next_state = w_next_state;
        end
    end

    // Line counter, region FSM and registered timing outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= '0;
            r_state       <= vga_timing_pkg::V_ACT;
            r_vde         <= 1'b1;
            r_vsync       <= ~SYNC_POL;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else if (Venable) begin
            r_count       <= w_next_count;
            r_state       <= w_next_state;
            r_vde         <= (w_next_state == vga_timing_pkg::V_ACT);
            r_vsync       <= (w_next_state == vga_timing_pkg::V_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_frame_start <= w_last;
            if (w_last) begin
                r_frame_cnt <= r_frame_cnt + C_FRAME_ONE;
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign count       = r_count;
    assign state       = r_state;
    assign vsync       = r_vsync;
    assign vde         = r_vde;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule
